// File: rtl/ant_symbol_buffer.sv
// Purpose : multi-bank RE buffer; collects whole symbols from the receive side and replays them in order.
// Latency : first RE out SYM_LEN+1+READ_LATENCY cycles after RE 0 is written; READ_LATENCY from read issue.
// Backpr. : write side never stalls; read address advances only while i_rready=1.
//
// Ports:
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_rx_data, i_rvalid       RE sample and write strobe
//   i_rready                  downstream ready
//   o_tx_data, o_tx_addr      buffered RE sample and its index inside the symbol
//   o_tx_last, o_tvalid       last-RE flag and output qualifier
// Option macro: ANT_SYM_BUF_OVF_PROTECT_EN drops a whole incoming symbol when every bank is occupied.

// Small first-word-fall-through FIFO used for the ready-symbol queue.
module ant_symbol_buffer_fifo #(
  parameter int DW    = 2,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_push,
  input  logic [DW-1:0] i_dat,
  input  logic          i_pop,
  output logic [DW-1:0] o_dat,
  output logic          o_empty,
  output logic [CW-1:0] o_count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic [DW-1:0] r_mem [0:DEPTH-1];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          w_full;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_empty   = (r_count == '0);
  assign w_full    = (r_count == CW'(DEPTH));
  assign w_do_pop  = i_pop && !o_empty;
  // A pop frees a slot in the same cycle, so push+pop on a full FIFO both happen.
  assign w_do_push = i_push && (!w_full || w_do_pop);
  assign o_dat     = r_mem[r_rptr];
  assign o_count   = r_count;

  always_ff @(posedge i_clk) begin
    if (w_do_push && !i_reset) r_mem[r_wptr] <= i_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= (r_wptr == LAST_PTR) ? '0 : r_wptr + 1'b1;
      if (w_do_pop)  r_rptr <= (r_rptr == LAST_PTR) ? '0 : r_rptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

module ant_symbol_buffer #(
  parameter int WDATA_WIDTH  = 128,
  parameter int WADDR_WIDTH  = 12,
  parameter int RDATA_WIDTH  = 128,
  parameter int RADDR_WIDTH  = 12,
  parameter int FIFO_DEPTH   = 8,
  parameter int FIFO_WIDTH   = 1,
  parameter int READ_LATENCY = 3,
  parameter int LOOP_WIDTH   = 15,
  parameter int INFO_WIDTH   = 1,
  parameter int RAM_TYPE     = 1,
  parameter int SYM_LEN      = 1584
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic [WDATA_WIDTH-1:0] i_rx_data,
  input  logic                   i_rvalid,
  input  logic                   i_rready,
  output logic [RDATA_WIDTH-1:0] o_tx_data,
  output logic [RADDR_WIDTH-1:0] o_tx_addr,
  output logic                   o_tx_last,
  output logic                   o_tvalid
);
  localparam int NB      = 2 ** FIFO_WIDTH;
  localparam int BANK_AW = WADDR_WIDTH - FIFO_WIDTH;
  localparam int FDW     = INFO_WIDTH + FIFO_WIDTH;
  localparam int FCW     = $clog2(FIFO_DEPTH + 1);
  localparam logic [BANK_AW-1:0] LAST_RE = BANK_AW'(SYM_LEN - 1);

  typedef enum logic {S_IDLE, S_READ} state_t;

  // Write side
  logic [BANK_AW-1:0]    r_wcnt;
  logic [FIFO_WIDTH-1:0] r_wbank;
  logic [LOOP_WIDTH-1:0] r_sym_cnt;
  logic                  w_wr_last;
  logic                  w_drop;
  logic                  w_wr_en;
  logic                  w_push;
  logic [WADDR_WIDTH-1:0] w_waddr;
  logic [FDW-1:0]        w_push_dat;

  // FIFO
  logic [FDW-1:0]        w_fifo_rdat;
  logic                  w_fifo_empty;
  logic [FCW-1:0]        w_fifo_cnt;
  logic [FIFO_WIDTH-1:0] w_fifo_bank;
  logic                  w_unused_bits;

  // Read FSM and issue stage
  state_t                r_state;
  state_t                w_state_nxt;
  logic [BANK_AW-1:0]    r_rcnt;
  logic [BANK_AW-1:0]    w_rcnt_nxt;
  logic [FIFO_WIDTH-1:0] r_rbank;
  logic [FIFO_WIDTH-1:0] w_rbank_nxt;
  logic                  w_pop;
  logic                  w_iss;
  logic [BANK_AW-1:0]    w_iss_re;
  logic [FIFO_WIDTH-1:0] w_iss_bank;
  logic                  r_iss_vld;
  logic [BANK_AW-1:0]    r_iss_re;
  logic [FIFO_WIDTH-1:0] r_iss_bank;
  logic [WADDR_WIDTH-1:0] w_raddr;

  // Output pipeline (stage 1 = RAM output register)
  logic [RDATA_WIDTH-1:0]  w_ram_q;
  logic [READ_LATENCY:1]   r_vld;
  logic [READ_LATENCY:1]   r_last;
  logic [RADDR_WIDTH-1:0]  r_addr [1:READ_LATENCY];

  assign w_wr_last  = i_rvalid && (r_wcnt == LAST_RE);
  assign w_wr_en    = i_rvalid && !w_drop && !i_reset;
  assign w_push     = w_wr_last && !w_drop;
  assign w_waddr    = {r_wbank, r_wcnt};
  assign w_push_dat = {r_sym_cnt[INFO_WIDTH-1:0], r_wbank};

`ifdef ANT_SYM_BUF_OVF_PROTECT_EN
  // The drop decision is taken once at RE 0 and held for the rest of the symbol,
  // so a symbol is either stored whole or not at all.
  logic w_wr_first;
  logic w_all_busy;
  logic r_drop;

  assign w_wr_first = i_rvalid && (r_wcnt == '0);

  always_comb begin
    w_all_busy = (int'(w_fifo_cnt) + ((r_state == S_READ) ? 1 : 0)) >= NB;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset)         r_drop <= 1'b0;
    else if (w_wr_first) r_drop <= w_all_busy;
  end

  assign w_drop = w_wr_first ? w_all_busy : r_drop;
`else
  assign w_drop = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wcnt    <= '0;
      r_wbank   <= '0;
      r_sym_cnt <= '0;
    end else if (i_rvalid) begin
      r_wcnt <= (r_wcnt == LAST_RE) ? '0 : r_wcnt + 1'b1;
      if (w_push) begin
        r_wbank   <= r_wbank + 1'b1;
        r_sym_cnt <= r_sym_cnt + 1'b1;
      end
    end
  end

  ant_symbol_buffer_fifo #(
    .DW    (FDW),
    .DEPTH (FIFO_DEPTH),
    .CW    (FCW)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (w_push),
    .i_dat   (w_push_dat),
    .i_pop   (w_pop),
    .o_dat   (w_fifo_rdat),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_cnt)
  );

  assign w_fifo_bank = w_fifo_rdat[FIFO_WIDTH-1:0];
  // The info tag travels with the bank index but has no consumer on this block's ports.
  assign w_unused_bits = ^{w_fifo_rdat[FDW-1:FIFO_WIDTH], w_fifo_cnt};

  // After the last RE the FSM drops to IDLE; IDLE pops and issues RE 0 in the
  // very next cycle when a symbol is waiting, so back-to-back symbols have no bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_rcnt_nxt  = r_rcnt;
    w_rbank_nxt = r_rbank;
    w_pop       = 1'b0;
    w_iss       = 1'b0;
    w_iss_re    = r_rcnt;
    w_iss_bank  = r_rbank;
    case (r_state)
      S_IDLE: begin
        if (!w_fifo_empty && i_rready) begin
          w_pop       = 1'b1;
          w_iss       = 1'b1;
          w_iss_re    = '0;
          w_iss_bank  = w_fifo_bank;
          w_rbank_nxt = w_fifo_bank;
          if (LAST_RE != '0) begin
            w_rcnt_nxt  = BANK_AW'(1);
            w_state_nxt = S_READ;
          end
        end
      end
      S_READ: begin
        if (i_rready) begin
          w_iss = 1'b1;
          if (r_rcnt == LAST_RE) begin
            w_rcnt_nxt  = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_rcnt_nxt = r_rcnt + 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_rcnt     <= '0;
      r_rbank    <= '0;
      r_iss_vld  <= 1'b0;
      r_iss_re   <= '0;
      r_iss_bank <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rcnt    <= w_rcnt_nxt;
      r_rbank   <= w_rbank_nxt;
      r_iss_vld <= w_iss;
      if (w_iss) begin
        r_iss_re   <= w_iss_re;
        r_iss_bank <= w_iss_bank;
      end
    end
  end

  assign w_raddr = {r_iss_bank, r_iss_re};

  // Both RAM styles present the read word one cycle after the issue register.
  if (RAM_TYPE == 1) begin : g_bram
    logic [RDATA_WIDTH-1:0] r_mem [0:(2**WADDR_WIDTH)-1];
    logic [RDATA_WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[w_waddr] <= i_rx_data;
    end

    always_ff @(posedge i_clk) begin
      if (i_reset)        r_q <= '0;
      else if (r_iss_vld) r_q <= r_mem[w_raddr];
    end

    assign w_ram_q = r_q;
  end else begin : g_dram
    logic [RDATA_WIDTH-1:0] r_mem [0:(2**WADDR_WIDTH)-1];
    logic [RDATA_WIDTH-1:0] w_lut_q;
    logic [RDATA_WIDTH-1:0] r_q;

    always_ff @(posedge i_clk) begin
      if (w_wr_en) r_mem[w_waddr] <= i_rx_data;
    end

    assign w_lut_q = r_mem[w_raddr];

    always_ff @(posedge i_clk) begin
      if (i_reset)        r_q <= '0;
      else if (r_iss_vld) r_q <= w_lut_q;
    end

    assign w_ram_q = r_q;
  end

  // Payload stages load only behind a valid, so the last output word is held
  // while o_tvalid is low.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 1; i <= READ_LATENCY; i++) begin
        r_vld[i]  <= 1'b0;
        r_last[i] <= 1'b0;
        r_addr[i] <= '0;
      end
    end else begin
      r_vld[1] <= r_iss_vld;
      if (r_iss_vld) begin
        r_addr[1] <= RADDR_WIDTH'(r_iss_re);
        r_last[1] <= (r_iss_re == LAST_RE);
      end
      for (int i = 2; i <= READ_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        if (r_vld[i-1]) begin
          r_addr[i] <= r_addr[i-1];
          r_last[i] <= r_last[i-1];
        end
      end
    end
  end

  if (READ_LATENCY == 1) begin : g_dat_direct
    assign o_tx_data = w_ram_q;
  end else begin : g_dat_pipe
    logic [RDATA_WIDTH-1:0] r_dat [2:READ_LATENCY];

    always_ff @(posedge i_clk) begin
      if (i_reset) begin
        for (int i = 2; i <= READ_LATENCY; i++) r_dat[i] <= '0;
      end else begin
        if (r_vld[1]) r_dat[2] <= w_ram_q;
        for (int i = 3; i <= READ_LATENCY; i++) begin
          if (r_vld[i-1]) r_dat[i] <= r_dat[i-1];
        end
      end
    end

    assign o_tx_data = r_dat[READ_LATENCY];
  end

  assign o_tvalid  = r_vld[READ_LATENCY];
  assign o_tx_addr = r_addr[READ_LATENCY];
  assign o_tx_last = r_vld[READ_LATENCY] && r_last[READ_LATENCY];
endmodule

// File: tb/tb_ant_symbol_buffer.sv
// Bench for ant_symbol_buffer: directed vectors plus multi-cycle stream scenarios.
module tb_ant_symbol_buffer;
  localparam int SYM_LEN = 1584;

  logic         clk = 1'b0;
  logic         i_reset;
  logic [127:0] i_rx_data;
  logic         i_rvalid;
  logic         i_rready;
  logic [127:0] o_tx_data;
  logic [11:0]  o_tx_addr;
  logic         o_tx_last;
  logic         o_tvalid;

  ant_symbol_buffer dut (
    .i_clk     (clk),
    .i_reset   (i_reset),
    .i_rx_data (i_rx_data),
    .i_rvalid  (i_rvalid),
    .i_rready  (i_rready),
    .o_tx_data (o_tx_data),
    .o_tx_addr (o_tx_addr),
    .o_tx_last (o_tx_last),
    .o_tvalid  (o_tvalid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] dat;
    int           addr;
    logic         last;
    int           cyc;
  } cap_t;

  typedef struct {
    int   off;
    logic vld;
    int   addr;
    logic last;
    int   sym;
  } vec_t;

  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   b_sym = 0;
  int   b_re  = 0;
  logic drv_wr  = 1'b0;
  logic drv_rdy = 1'b1;
  logic drv_rst = 1'b1;
  cap_t cap_q[$];
  int   exp_syms[$];
  vec_t vec [0:10];

  function automatic logic [127:0] mk(input int s, input int a);
    return {64'd0, 32'(s), 32'(a)};
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one cycle, advance the write counters, sample outputs 1 ns after the edge.
  task automatic step();
    i_reset   = drv_rst;
    i_rvalid  = drv_wr;
    i_rx_data = drv_wr ? mk(b_sym, b_re) : '0;
    i_rready  = drv_rdy;
    @(posedge clk);
    #1;
    cyc++;
    if (drv_wr && !drv_rst) begin
      if (b_re == SYM_LEN - 1) begin
        b_re = 0;
        b_sym++;
      end else begin
        b_re++;
      end
    end
    if (o_tvalid) cap_q.push_back('{dat: o_tx_data, addr: int'(o_tx_addr), last: o_tx_last, cyc: cyc});
  endtask

  task automatic do_reset(input int n);
    drv_rst = 1'b1;
    drv_wr  = 1'b0;
    repeat (n) step();
    drv_rst = 1'b0;
    cap_q.delete();
    b_sym = 0;
    b_re  = 0;
  endtask

  // Compare captured stream against the symbol-tag sequence in exp_syms.
  task automatic verify_stream(input string name);
    int total;
    int n_ok;
    total = exp_syms.size() * SYM_LEN;
    n_ok  = 0;
    chk({name, "_count"}, cap_q.size(), total);
    for (int i = 0; i < cap_q.size() && i < total; i++) begin
      int s;
      int a;
      s = exp_syms[i / SYM_LEN];
      a = i % SYM_LEN;
      if (cap_q[i].addr == a && cap_q[i].last == (a == SYM_LEN - 1) && cap_q[i].dat == mk(s, a))
        n_ok++;
    end
    chk({name, "_content"}, n_ok, total);
  endtask

  task automatic count_gaps(output int ngap, output int nidle);
    ngap  = 0;
    nidle = 0;
    for (int i = 1; i < cap_q.size(); i++) begin
      int d;
      d = cap_q[i].cyc - cap_q[i-1].cyc - 1;
      if (d != 0) begin
        ngap++;
        nidle += d;
      end
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int ngap;
    int nidle;

    // Offsets are cycles after the first write; RE 0 appears at SYM_LEN+1+3.
    vec[0]  = '{off: 1587, vld: 1'b0, addr: 0,    last: 1'b0, sym: 0};
    vec[1]  = '{off: 1588, vld: 1'b1, addr: 0,    last: 1'b0, sym: 0};
    vec[2]  = '{off: 1589, vld: 1'b1, addr: 1,    last: 1'b0, sym: 0};
    vec[3]  = '{off: 1590, vld: 1'b1, addr: 2,    last: 1'b0, sym: 0};
    vec[4]  = '{off: 3170, vld: 1'b1, addr: 1582, last: 1'b0, sym: 0};
    vec[5]  = '{off: 3171, vld: 1'b1, addr: 1583, last: 1'b1, sym: 0};
    vec[6]  = '{off: 3172, vld: 1'b1, addr: 0,    last: 1'b0, sym: 1};
    vec[7]  = '{off: 4755, vld: 1'b1, addr: 1583, last: 1'b1, sym: 1};
    vec[8]  = '{off: 4756, vld: 1'b1, addr: 0,    last: 1'b0, sym: 2};
    vec[9]  = '{off: 6339, vld: 1'b1, addr: 1583, last: 1'b1, sym: 2};
    vec[10] = '{off: 6340, vld: 1'b0, addr: 0,    last: 1'b0, sym: 0};

    // Reset state
    do_reset(3);
    chk("rst_tvalid", o_tvalid, 0);
    chk("rst_last", o_tx_last, 0);
    chk("rst_addr", o_tx_addr, 0);
    chk("rst_data", o_tx_data, 0);

    // Three back-to-back symbols, always ready
    drv_rdy = 1'b1;
    w = cyc;
    for (int v = 0; v <= 10; v++) begin
      while (cyc - w < vec[v].off) begin
        drv_wr = (cyc - w) < 3 * SYM_LEN;
        step();
      end
      chk($sformatf("vec%0d_vld", v), o_tvalid, vec[v].vld);
      if (vec[v].vld) begin
        chk($sformatf("vec%0d_addr", v), o_tx_addr, vec[v].addr);
        chk($sformatf("vec%0d_last", v), o_tx_last, vec[v].last);
        chk($sformatf("vec%0d_data", v), o_tx_data, mk(vec[v].sym, vec[v].addr));
      end
    end
    drv_wr = 1'b0;
    repeat (5) step();
    chk("hold_addr", o_tx_addr, SYM_LEN - 1);
    chk("hold_data", o_tx_data, mk(2, SYM_LEN - 1));
    chk("hold_last", o_tx_last, 0);
    exp_syms = '{0, 1, 2};
    verify_stream("b2b");
    count_gaps(ngap, nidle);
    chk("b2b_gaps", ngap, 0);

    // Ten-cycle backpressure in the middle of a symbol
    do_reset(2);
    for (int k = 0; k < 2 * SYM_LEN + 1600; k++) begin
      drv_wr  = k < 2 * SYM_LEN;
      drv_rdy = !(k >= 2100 && k < 2110);
      step();
    end
    drv_rdy = 1'b1;
    exp_syms = '{0, 1};
    verify_stream("stall");
    count_gaps(ngap, nidle);
    chk("stall_gap_count", ngap, 1);
    chk("stall_gap_len", nidle, 10);

    // Reset pulse at RE 700 of symbol 2
    do_reset(2);
    for (int k = 0; k < 2 * SYM_LEN + 700; k++) begin
      drv_wr = 1'b1;
      step();
    end
    chk("prerst_tvalid", o_tvalid, 1);
    drv_rst = 1'b1;
    drv_wr  = 1'b0;
    step();
    chk("midrst_tvalid", o_tvalid, 0);
    chk("midrst_last", o_tx_last, 0);
    chk("midrst_addr", o_tx_addr, 0);
    chk("midrst_data", o_tx_data, 0);
    step();
    step();
    drv_rst = 1'b0;
    cap_q.delete();
    b_sym = 7;
    b_re  = 0;
    for (int k = 0; k < SYM_LEN + 1600; k++) begin
      drv_wr = k < SYM_LEN;
      step();
    end
    exp_syms = '{7};
    verify_stream("postrst");

    // Three symbols written while downstream is not ready
    do_reset(2);
    drv_rdy = 1'b0;
    for (int k = 0; k < 3 * SYM_LEN + 5; k++) begin
      drv_wr = k < 3 * SYM_LEN;
      step();
    end
    chk("norady_out", cap_q.size(), 0);
    drv_rdy = 1'b1;
    for (int k = 0; k < 3 * SYM_LEN + 100; k++) step();
`ifdef ANT_SYM_BUF_OVF_PROTECT_EN
    exp_syms = '{0, 1};
`else
    exp_syms = '{2, 1, 2};
`endif
    verify_stream("ovf");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ant_symbol_buffer.md
ANT_SYMBOL_BUFFER -- requirements
Module: ant_symbol_buffer

Interface
REQ-001 SHALL have parameter WDATA_WIDTH, default 128: write data width (4 antennas x 32-bit IQ).
REQ-002 SHALL have parameter WADDR_WIDTH, default 12: total RAM address width, giving 4096 words.
REQ-003 SHALL have parameter RDATA_WIDTH, default 128: read data width; must equal WDATA_WIDTH.
REQ-004 SHALL have parameter RADDR_WIDTH, default 12: width of o_tx_addr.
REQ-005 SHALL have parameter FIFO_DEPTH, default 8: depth of the ready-symbol FIFO.
REQ-006 SHALL have parameter FIFO_WIDTH, default 1: bank-index width; number of banks NB = 2^FIFO_WIDTH.
REQ-007 SHALL have parameter READ_LATENCY, default 3: cycles from RAM read address to o_tvalid.
REQ-008 SHALL have parameter LOOP_WIDTH, default 15: width of the wrapping completed-symbol counter.
REQ-009 SHALL have parameter INFO_WIDTH, default 1: width of the per-symbol info tag stored in the FIFO beside the bank index (tag = LSBs of the symbol counter).
REQ-010 SHALL have parameter RAM_TYPE, default 1: 1 = block RAM, 0 = distributed RAM; cycle behaviour is identical for both.
REQ-011 SHALL have parameter SYM_LEN, default 1584: REs per symbol (132 PRB x 12); SYM_LEN <= 2^WADDR_WIDTH/NB.
REQ-012 i_clk  in  1  sole clock.
REQ-013 i_reset  in  1  synchronous, active-high reset.
REQ-014 i_rx_data  in  WDATA_WIDTH  RE sample, written when i_rvalid=1.
REQ-015 i_rvalid  in  1  write strobe; no backpressure.
REQ-016 i_rready  in  1  downstream ready; read address advances only while 1.
REQ-017 o_tx_data  out  RDATA_WIDTH  buffered RE sample.
REQ-018 o_tx_addr  out  RADDR_WIDTH  RE index within symbol, 0..SYM_LEN-1.
REQ-019 o_tx_last  out  1  high with o_tvalid when o_tx_addr = SYM_LEN-1.
REQ-020 o_tvalid  out  1  output qualifier.

Function
REQ-021 Write side: the RE counter wcnt addresses bank wbank at offset wcnt; each i_rvalid writes and increments wcnt, which wraps SYM_LEN-1 -> 0.
REQ-022 On the write with wcnt = SYM_LEN-1: {info, wbank} SHALL be pushed to the FIFO, wbank SHALL advance modulo NB, and the symbol counter SHALL increment, wrapping at 2^LOOP_WIDTH.
REQ-023 Read FSM states: IDLE and READ. IDLE -> READ when the FIFO is non-empty and i_rready=1; that cycle pops the FIFO and issues address 0.
REQ-024 In READ, each cycle with i_rready=1 issues the next address; when i_rready=0 the address holds and no read is issued.
REQ-025 After issuing SYM_LEN-1, the FSM SHALL pop the next entry and issue address 0 of that entry in the next cycle if the FIFO is non-empty and i_rready=1 (no bubble); otherwise it returns to IDLE.
REQ-026 o_tvalid, o_tx_data, o_tx_addr and o_tx_last SHALL appear exactly READ_LATENCY cycles after the corresponding issue; o_tvalid=0 on all other cycles.
REQ-027 A simultaneous FIFO push and pop SHALL both take effect; a push while full is ignored.
REQ-028 o_tx_data and o_tx_addr SHALL hold their last values while o_tvalid=0.

Reset
REQ-029 While i_reset=1: wcnt=0, wbank=0, symbol counter=0, FIFO empty, FSM=IDLE, read pipeline flushed.
REQ-030 While i_reset=1 all outputs SHALL be 0; asserting reset mid-symbol discards partial and queued symbols, and the first RE after reset is RE 0 of bank 0.

Configuration
REQ-031 Macro ANT_SYM_BUF_OVF_PROTECT_EN defined: if, at RE 0 of a symbol, all NB banks are occupied (queued or being read), that entire symbol's writes and its push SHALL be suppressed and wbank SHALL not advance.
REQ-032 Macro undefined: writes and pushes SHALL always proceed, overwriting occupied banks.

Verification
REQ-033 Continuous i_rvalid=1 with i_rready=1 and data=RE index: the first o_tvalid occurs SYM_LEN+1+READ_LATENCY cycles after the first write, and o_tx_addr sequences 0..1583 with o_tx_last at 1583.
REQ-034 Three back-to-back symbols: output shows no gap between symbols, and the data of symbol k equals input symbol k.
REQ-035 i_rready=0 for 10 cycles mid-symbol: o_tvalid gap of 10 cycles, no RE lost or duplicated.
REQ-036 Reset pulse at RE 700 of symbol 2: outputs are 0 during reset, and the next output symbol carries the post-reset data starting at addr 0.
REQ-037 i_rready=0 for 3 symbols with the macro defined: symbols 0-1 are retained, symbol 2 is dropped, and after i_rready=1 exactly symbols 0 and 1 are output.
